action_result_queue: RTL
========================

Name: action_result_queue

Overview:
- Downstream stage of the selector's combine chain: captures the final chain output (highest-priority match, or miss) each cycle it is valid.
- Buffers results in a small FIFO and presents them on a valid/ready interface to the output-port/action application stage.
- Maintains saturating hit/miss/drop statistics counters for the register interface.

Parameters:
C_OUT_PORT_WIDTH, 8, width of physical and virtual output port fields
C_MATCH_ADDR_WIDTH, 10, width of matched flow-table entry address
C_FIFO_DEPTH, 4, result FIFO entries (power of two, >=2)
C_CNT_WIDTH, 32, width of each statistics counter

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous active-low reset
in_valid  in  1  chain result valid (single-cycle, no backpressure upstream)
in_match  in  1  chain result is a table hit
in_type  in  2  action type of result
in_port  in  C_OUT_PORT_WIDTH  physical output port
in_vport  in  C_OUT_PORT_WIDTH  virtual output port
in_match_addr  in  C_MATCH_ADDR_WIDTH  matched entry address
out_valid  out  1  head entry available
out_ready  in  1  consumer accepts head entry
out_match  out  1  head: hit flag
out_type  out  2  head: action type
out_port  out  C_OUT_PORT_WIDTH  head: physical port
out_vport  out  C_OUT_PORT_WIDTH  head: virtual port
out_match_addr  out  C_MATCH_ADDR_WIDTH  head: entry address
fifo_full  out  1  FIFO holds C_FIFO_DEPTH entries
clear_counters  in  1  synchronous counter clear pulse
hit_count  out  C_CNT_WIDTH  accepted hits
miss_count  out  C_CNT_WIDTH  accepted misses
drop_count  out  C_CNT_WIDTH  results dropped on overflow

Behaviour:
- Reset (rst_n=0 at posedge): FIFO emptied (wr/rd pointers and occupancy 0), out_valid=0, all out_* data fields 0, fifo_full=0, all counters 0. Reset mid-transfer discards all queued entries; no partial state survives.
- Miss normalisation on push: if in_match=0, stored type/port/vport/match_addr are forced to 0 and match=0; hit entries stored unmodified.
- Push: in_valid=1 and (occupancy<C_FIFO_DEPTH or pop in same cycle). Pop: out_valid && out_ready.
- Simultaneous push+pop when full: both occur, occupancy unchanged, no drop.
- Push when full without pop: result dropped, drop_count increments, FIFO unchanged.
- Latency: result presented at posedge N appears on out_* with out_valid=1 after posedge N (visible cycle N+1) when FIFO was empty; out_* registered, no combinational path from in_* to out_*.
- out_* stable while out_valid=1 and out_ready=0. When out_valid=0, out_* data are 0.
- Pointers wrap modulo C_FIFO_DEPTH; occupancy counter width clog2(C_FIFO_DEPTH)+1. fifo_full registered, equals (occupancy==C_FIFO_DEPTH).
- Counters: hit_count +1 on accepted push with in_match=1; miss_count +1 on accepted push with in_match=0; drop_count +1 on dropped push (hit or miss). All saturate at all-ones.
- clear_counters=1: all three counters to 0 at that edge; clear wins over a same-cycle increment (that event is not counted). FIFO unaffected.
- out_ready while out_valid=0 is ignored.

Decomposition:
- Shared package (parameters.v): C_OUT_PORT_WIDTH, C_MATCH_ADDR_WIDTH, action-type encodings, packed struct action_result_t {match, type, port, vport, match_addr} reused by the combine chain and this block.
- One sub-module natural: sync_fifo (parameterised width/depth, registered output, full/empty, simultaneous push/pop when full). Counters and miss normalisation stay in the top.

Test Plan:
- Single hit in_port=3, vport=5, type=2, addr=0x2A, out_ready=1 -> one cycle later out_valid=1 with those values, hit_count=1, miss_count=0.
- Miss in_match=0, in_port=7, type=3 -> out_valid=1, out_match=0, port/vport/type/addr all 0, miss_count=1.
- out_ready=0, push 5 hits (depth 4) -> fifo_full=1 after 4th, drop_count=1, hit_count=4; then out_ready=1 -> first 4 results drain in order, out_valid=0 afterwards.
- FIFO full, out_ready=1 and in_valid=1 same cycle -> no drop, drop_count unchanged, new entry emerges last in order.
- Preload hit_count=2^C_CNT_WIDTH-1 (force or long run with C_CNT_WIDTH=4: 16 hits) -> stays at 15; clear_counters with simultaneous hit -> hit_count=0.
- 3 entries queued, rst_n=0 one cycle -> out_valid=0, fifo_full=0, counters 0; next push appears as sole entry.

Source files
------------

// File: rtl/action_result_queue_pkg.sv
// -----------------------------------------------------------------------------
// action_result_queue_pkg
// Shared definitions for the selector combine chain and the action result
// queue: field widths, action-type encodings and the packed result record.
// No ports (package).
// -----------------------------------------------------------------------------
package action_result_queue_pkg;

  localparam int C_OUT_PORT_WIDTH   = 8;
  localparam int C_MATCH_ADDR_WIDTH = 10;

  typedef enum logic [1:0] {
    ACT_NONE   = 2'd0,
    ACT_OUTPUT = 2'd1,
    ACT_VPORT  = 2'd2,
    ACT_DROP   = 2'd3
  } action_type_t;

  typedef struct packed {
    logic                          match;
    action_type_t                  act_type;
    logic [C_OUT_PORT_WIDTH-1:0]   port;
    logic [C_OUT_PORT_WIDTH-1:0]   vport;
    logic [C_MATCH_ADDR_WIDTH-1:0] match_addr;
  } action_result_t;

  localparam int C_RESULT_WIDTH = $bits(action_result_t);

  // Assemble a result record from its individual fields, unmodified.
  function automatic action_result_t make_result(
    input logic                          match,
    input action_type_t                  act_type,
    input logic [C_OUT_PORT_WIDTH-1:0]   port,
    input logic [C_OUT_PORT_WIDTH-1:0]   vport,
    input logic [C_MATCH_ADDR_WIDTH-1:0] match_addr
  );
    action_result_t r;
    r.match      = match;
    r.act_type   = act_type;
    r.port       = port;
    r.vport      = vport;
    r.match_addr = match_addr;
    return r;
  endfunction

endpackage

// File: rtl/action_result_queue_if.sv
// -----------------------------------------------------------------------------
// action_result_queue_if
// Bundles the chain-result input (in_*) and the queued-result output
// (out_* with out_valid/out_ready handshake) of the action result queue.
//   master : the surrounding logic (drives in_*, out_ready; observes out_*)
//   slave  : the queue itself (observes in_*, out_ready; drives out_*)
// -----------------------------------------------------------------------------
interface action_result_queue_if
  import action_result_queue_pkg::*;
;

  // Chain result input (single-cycle valid, no upstream backpressure)
  logic                          in_valid;
  logic                          in_match;
  logic [1:0]                    in_type;
  logic [C_OUT_PORT_WIDTH-1:0]   in_port;
  logic [C_OUT_PORT_WIDTH-1:0]   in_vport;
  logic [C_MATCH_ADDR_WIDTH-1:0] in_match_addr;

  // Queue head output
  logic                          out_valid;
  logic                          out_ready;
  logic                          out_match;
  logic [1:0]                    out_type;
  logic [C_OUT_PORT_WIDTH-1:0]   out_port;
  logic [C_OUT_PORT_WIDTH-1:0]   out_vport;
  logic [C_MATCH_ADDR_WIDTH-1:0] out_match_addr;

  modport master (
    output in_valid, in_match, in_type, in_port, in_vport, in_match_addr,
    output out_ready,
    input  out_valid, out_match, out_type, out_port, out_vport, out_match_addr
  );

  modport slave (
    input  in_valid, in_match, in_type, in_port, in_vport, in_match_addr,
    input  out_ready,
    output out_valid, out_match, out_type, out_port, out_vport, out_match_addr
  );

endinterface

// File: rtl/action_result_queue_sync_fifo.sv
// -----------------------------------------------------------------------------
// action_result_queue_sync_fifo
// Synchronous FIFO with a registered head output. The head register is loaded
// from the next-state view of the FIFO, so an entry pushed into an empty FIFO
// is visible the cycle after the push edge. A push into a full FIFO is
// accepted when the head is popped in the same cycle.
// Ports:
//   clk, rst_n   clock, synchronous active-low reset
//   push_i       write request
//   wdata_i      write data
//   ready_i      consumer ready (pop happens only while valid_o=1)
//   rdata_o      head data (zero when empty)
//   valid_o      head entry available
//   full_o       occupancy equals DEPTH (registered)
//   push_ok_o    write request accepted this cycle
// -----------------------------------------------------------------------------
module action_result_queue_sync_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push_i,
  input  logic [W-1:0] wdata_i,
  input  logic         ready_i,
  output logic [W-1:0] rdata_o,
  output logic         valid_o,
  output logic         full_o,
  output logic         push_ok_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = $clog2(DEPTH) + 1;

  logic [W-1:0]     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0] occ_q, occ_d;
  logic             valid_q, valid_d;
  logic             full_q, full_d;
  logic [W-1:0]     rdata_q, rdata_d;
  logic             pop;
  logic             push_ok;

  assign pop     = valid_q && ready_i;
  assign push_ok = push_i && (!full_q || pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)     rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push_ok, pop})
      2'b10:   occ_d = occ_q + 1'b1;
      2'b01:   occ_d = occ_q - 1'b1;
      default: occ_d = occ_q;
    endcase
    full_d  = (occ_d == OCC_W'(DEPTH));
    valid_d = (occ_d != '0);
    // Next head: when the post-pop read pointer lands on the slot being
    // written this cycle, every older entry is gone and the head is the
    // incoming word (full-without-pop cannot reach here: push is rejected).
    rdata_d = '0;
    if (valid_d) begin
      if (push_ok && (rd_ptr_d == wr_ptr_q)) rdata_d = wdata_i;
      else                                   rdata_d = mem_q[rd_ptr_d];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
      valid_q  <= 1'b0;
      full_q   <= 1'b0;
      rdata_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
      valid_q  <= valid_d;
      full_q   <= full_d;
      rdata_q  <= rdata_d;
    end
  end

  // Storage is unreachable after reset (pointers cleared), so it needs none.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o   = rdata_q;
  assign valid_o   = valid_q;
  assign full_o    = full_q;
  assign push_ok_o = push_ok;

endmodule

// File: rtl/action_result_queue.sv
// -----------------------------------------------------------------------------
// action_result_queue
// Captures the final combine-chain result each cycle it is valid, normalises
// misses to an all-zero record, buffers results in a small FIFO and presents
// them on a valid/ready interface. Keeps saturating hit/miss/drop counters.
// Ports:
//   clk, rst_n       clock, synchronous active-low reset
//   q_if (slave)     in_* chain result input, out_* queue head + handshake
//   fifo_full        FIFO holds C_FIFO_DEPTH entries
//   clear_counters   synchronous clear of all counters (wins over increments)
//   hit_count        accepted hits
//   miss_count       accepted misses
//   drop_count       results dropped because the FIFO was full
// -----------------------------------------------------------------------------
module action_result_queue
  import action_result_queue_pkg::*;
#(
  parameter int C_FIFO_DEPTH = 4,
  parameter int C_CNT_WIDTH  = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  action_result_queue_if.slave   q_if,
  output logic                   fifo_full,
  input  logic                   clear_counters,
  output logic [C_CNT_WIDTH-1:0] hit_count,
  output logic [C_CNT_WIDTH-1:0] miss_count,
  output logic [C_CNT_WIDTH-1:0] drop_count
);

  function automatic logic [C_CNT_WIDTH-1:0] sat_inc(input logic [C_CNT_WIDTH-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  action_result_t            in_res;
  logic [C_RESULT_WIDTH-1:0] head_bits;
  action_result_t            head;
  logic                      push_ok;

  logic [C_CNT_WIDTH-1:0] hit_cnt_q,  hit_cnt_d;
  logic [C_CNT_WIDTH-1:0] miss_cnt_q, miss_cnt_d;
  logic [C_CNT_WIDTH-1:0] drop_cnt_q, drop_cnt_d;

  // A miss carries no meaningful action fields; store it as all zero so the
  // consumer never acts on stale chain data.
  always_comb begin
    in_res = '0;
    if (q_if.in_match) begin
      in_res = make_result(1'b1, action_type_t'(q_if.in_type), q_if.in_port,
                           q_if.in_vport, q_if.in_match_addr);
    end
  end

  action_result_queue_sync_fifo #(
    .W     (C_RESULT_WIDTH),
    .DEPTH (C_FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push_i    (q_if.in_valid),
    .wdata_i   (in_res),
    .ready_i   (q_if.out_ready),
    .rdata_o   (head_bits),
    .valid_o   (q_if.out_valid),
    .full_o    (fifo_full),
    .push_ok_o (push_ok)
  );

  assign head                = action_result_t'(head_bits);
  assign q_if.out_match      = head.match;
  assign q_if.out_type       = head.act_type;
  assign q_if.out_port       = head.port;
  assign q_if.out_vport      = head.vport;
  assign q_if.out_match_addr = head.match_addr;

  always_comb begin
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    drop_cnt_d = drop_cnt_q;
    if (clear_counters) begin
      hit_cnt_d  = '0;
      miss_cnt_d = '0;
      drop_cnt_d = '0;
    end else begin
      if (push_ok &&  q_if.in_match)      hit_cnt_d  = sat_inc(hit_cnt_q);
      if (push_ok && !q_if.in_match)      miss_cnt_d = sat_inc(miss_cnt_q);
      if (q_if.in_valid && !push_ok)      drop_cnt_d = sat_inc(drop_cnt_q);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
      drop_cnt_q <= '0;
    end else begin
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign hit_count  = hit_cnt_q;
  assign miss_count = miss_cnt_q;
  assign drop_count = drop_cnt_q;

endmodule
